banner_uart_reporter: RTL and testbench
=======================================

Name: banner_uart_reporter

Overview:
- Transmit-side companion to the UART-controlled banner: reports the banner's current state back over the UART link.
- On a request pulse, or periodically, it snapshots the six displayed digits and the play/direction status.
- It formats the snapshot as an ASCII frame and pushes it byte-by-byte into the UART transmit FIFO using the wr_uart/tx_full write handshake.

Parameters:
- PERIOD, 50_000_000, auto-report interval in clk cycles (1 s at 50 MHz).
- PERIOD_W, 26, width of the auto-report counter; must satisfy 2^PERIOD_W > PERIOD.
- AUTO, 0, 1 enables periodic reports; 0 means reports are sent only on req.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- req  in  1  single-cycle report request (e.g. '?' decoded upstream)
- en  in  1  banner play status (1 = playing)
- dir  in  1  banner direction (0 = left, 1 = right)
- d5,d4,d3,d2,d1,d0  in  5 each  displayed digits {dp, hex}, d5 leftmost
- tx_full  in  1  UART TX FIFO full
- wr_uart  out  1  one-cycle FIFO write strobe
- w_data  out  8  byte written when wr_uart=1
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the LF byte is written

Behaviour:
- Reset values: wr_uart=0, w_data=8'h00, busy=0, frame_done=0, pending=0, auto counter=0, state=IDLE.
- Frame order:
  - d5..d0 as ASCII hex: 0-9 map to 8'h30+n; A-F map to 8'h41+(n-10).
  - Any digit with dp=1 is immediately followed by '.' (8'h2E).
  - Then ' ' (8'h20), status 'G'/'P' (8'h47/8'h50), direction 'L'/'R' (8'h4C/8'h52), CR (8'h0D), LF (8'h0A).
  - Frame length ranges from 11 to 17 bytes.
- Snapshot: d5..d0, en and dir are registered into an internal buffer on the IDLE->DIGIT transition. Input changes mid-frame do not affect the frame in progress.
- FSM states: IDLE, DIGIT, DOT, SEP, STAT, DIRC, CR, LF.
  - IDLE: go to DIGIT (index=5) when req or pending or auto_tick.
  - DIGIT: emit digit[index]. Next state is DOT if its dp=1; otherwise DIGIT with index-1, or SEP after index 0.
  - DOT: emit '.', then DIGIT (index-1), or SEP after index 0.
  - SEP -> STAT -> DIRC -> CR -> LF -> IDLE. frame_done pulses in the cycle after the LF write.
- Handshake:
  - A byte is written only in a cycle where tx_full=0. wr_uart is registered, asserted for exactly one cycle per byte, with w_data valid in the same cycle.
  - A state advances only after its byte is written. While tx_full=1 the FSM holds with wr_uart=0; no byte is lost or duplicated.
  - Throughput is at most 1 byte per clk.
- busy=1 from the cycle after the trigger until the frame_done cycle inclusive.
- Requests:
  - req while busy sets pending. Multiple reqs while busy collapse into one extra frame.
  - pending clears when the next frame starts.
  - req in the same cycle frame_done pulses is captured as pending.
- Auto-report (AUTO=1):
  - Counter increments every cycle and wraps at PERIOD-1, producing a one-cycle auto_tick.
  - auto_tick while busy sets pending, exactly as req does.
  - AUTO=0 means the counter is held at 0.
- Reset mid-frame: everything returns to reset values immediately, and the frame is truncated. No partial continuation after reset is released.

Test Plan:
- Digits 0,1,2,3,4,5 (dp=0), en=1, dir=0, tx_full=0, req pulse -> bytes 30 31 32 33 34 35 20 47 4C 0D 0A on consecutive cycles, then frame_done pulse.
- d5=5'h1A, d2=5'h0F (dp set on d5), others 0, en=0, dir=1 -> 41 2E 30 30 46 30 30 20 50 52 0D 0A (12 bytes).
- Hold tx_full=1 for 5 cycles after the 3rd byte -> wr_uart stays low during the hold, the 4th byte appears after release, and the total byte count is unchanged.
- Three req pulses during a frame -> exactly two frames in total, back-to-back; pending clears when the second frame starts.
- AUTO=1, PERIOD=100, no req -> a frame starts every 100 cycles; change d0 mid-frame -> the new value appears only in the next frame.
- Assert rst_n=0 on the 6th byte -> wr_uart=0 and busy=0 immediately; no bytes after release until a new req.

Source files
------------

// File: rtl/banner_uart_reporter.sv
// banner_uart_reporter: snapshots banner digits/status and streams them as an ASCII frame into the UART TX FIFO
module banner_uart_reporter #(
  parameter int PERIOD   = 50_000_000,
  parameter int PERIOD_W = 26,
  parameter bit AUTO     = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       en,
  input  logic       dir,
  input  logic [4:0] d5,
  input  logic [4:0] d4,
  input  logic [4:0] d3,
  input  logic [4:0] d2,
  input  logic [4:0] d1,
  input  logic [4:0] d0,
  input  logic       tx_full,
  output logic       wr_uart,
  output logic [7:0] w_data,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [2:0] {IDLE, DIGIT, DOT, SEP, STAT, DIRC, CR, LF} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [29:0] snap_q, snap_d;
  logic en_s_q, en_s_d, dir_s_q, dir_s_d;
  logic pending_q, pending_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [7:0] data_q, data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic lf_q, lf_d;
  logic tick, start, last;
  logic [4:0] digit;
  logic [7:0] asc;
  assign tick    = AUTO && (cnt_q == PERIOD_W'(PERIOD - 1));
  // a new frame waits until the previous frame_done cycle has passed, so a req there lands in pending
  assign start   = (state_q == IDLE) && !busy_q && (req || pending_q || tick);
  assign last    = (idx_q == 3'd0);
  assign digit   = snap_q[5'(idx_q) * 5'd5 +: 5];
  assign asc     = (digit[3:0] < 4'd10) ? 8'h30 + {4'h0, digit[3:0]} : 8'h37 + {4'h0, digit[3:0]};
  assign wr_uart    = wr_q;
  assign w_data     = data_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  // next-state, byte selection and request bookkeeping
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    en_s_d    = en_s_q;
    dir_s_d   = dir_s_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    lf_d      = 1'b0;
    done_d    = lf_q;
    busy_d    = start ? 1'b1 : done_q ? 1'b0 : busy_q;
    pending_d = start ? 1'b0 : (busy_q && (req || tick)) ? 1'b1 : pending_q;
    cnt_d     = !AUTO ? '0 : tick ? '0 : cnt_q + 1'b1;
    if (start) begin
      state_d = DIGIT;
      idx_d   = 3'd5;
      snap_d  = {d5, d4, d3, d2, d1, d0};
      en_s_d  = en;
      dir_s_d = dir;
    end else if (state_q != IDLE && !tx_full) begin
      wr_d = 1'b1;
      lf_d = (state_q == LF);
      case (state_q)
        DIGIT: begin
          data_d  = asc;
          state_d = digit[4] ? DOT : last ? SEP : DIGIT;
          idx_d   = (digit[4] || last) ? idx_q : idx_q - 3'd1;
        end
        DOT: begin
          data_d  = 8'h2E;
          state_d = last ? SEP : DIGIT;
          idx_d   = last ? idx_q : idx_q - 3'd1;
        end
        SEP: begin
          data_d  = 8'h20;
          state_d = STAT;
        end
        STAT: begin
          data_d  = en_s_q ? 8'h47 : 8'h50;
          state_d = DIRC;
        end
        DIRC: begin
          data_d  = dir_s_q ? 8'h52 : 8'h4C;
          state_d = CR;
        end
        CR: begin
          data_d  = 8'h0D;
          state_d = LF;
        end
        default: begin
          data_d  = 8'h0A;
          state_d = IDLE;
        end
      endcase
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      en_s_q    <= 1'b0;
      dir_s_q   <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      en_s_q    <= en_s_d;
      dir_s_q   <= dir_s_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lf_q      <= lf_d;
    end
  end
endmodule

// File: tb/tb_banner_uart_reporter.sv
// tb_banner_uart_reporter: directed self-checking bench for banner_uart_reporter
module tb_banner_uart_reporter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_a = 1'b0;
  logic req = 1'b0;
  logic en = 1'b0;
  logic dir = 1'b0;
  logic [4:0] d5 = '0, d4 = '0, d3 = '0, d2 = '0, d1 = '0, d0 = '0;
  logic tx_full = 1'b0;
  logic wr_uart, busy, frame_done;
  logic [7:0] w_data;
  logic wr_a, busy_a, fd_a;
  logic [7:0] wd_a;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] qm[$];
  int tm[$];
  logic [7:0] qa[$];
  int fda[$];
  logic [7:0] exp1 [11] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h20, 8'h47, 8'h4C, 8'h0D, 8'h0A};
  logic [7:0] exp2 [12] = '{8'h41, 8'h2E, 8'h30, 8'h30, 8'h46, 8'h30, 8'h30, 8'h20, 8'h50, 8'h52, 8'h0D, 8'h0A};

  banner_uart_reporter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .dir(dir),
    .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .frame_done(frame_done)
  );

  banner_uart_reporter #(.PERIOD(100), .PERIOD_W(8), .AUTO(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a), .req(1'b0), .en(en), .dir(dir),
    .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .tx_full(1'b0), .wr_uart(wr_a), .w_data(wd_a), .busy(busy_a), .frame_done(fd_a)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // byte and frame_done capture for both instances
  always @(negedge clk) begin
    if (wr_uart) begin
      qm.push_back(w_data);
      tm.push_back(cyc);
    end
    if (wr_a) qa.push_back(wd_a);
    if (fd_a) fda.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, frame_done}, 32'd1);
  endtask

  task automatic wait_bytes(input int k, input string tag);
    int c = 0;
    int n = 0;
    while (c < k && n < 200) begin
      @(negedge clk);
      if (wr_uart) c++;
      n++;
    end
    chk(tag, c, k);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr", {31'd0, wr_uart}, 32'd0);
    chk("rst_data", {24'd0, w_data}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // frame 1: plain digits 0..5, playing, left
    {d5, d4, d3, d2, d1, d0} = {5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5};
    en = 1'b1;
    dir = 1'b0;
    qm.delete();
    tm.delete();
    pulse_req();
    chk("f1_busy_start", {31'd0, busy}, 32'd1);
    wait_done("f1_done");
    chk("f1_busy_at_done", {31'd0, busy}, 32'd1);
    chk("f1_len", qm.size(), 11);
    for (int i = 0; i < 11 && i < qm.size(); i++) chk($sformatf("f1_byte%0d", i), {24'd0, qm[i]}, {24'd0, exp1[i]});
    if (tm.size() == 11) chk("f1_consecutive", tm[10] - tm[0], 10);
    @(negedge clk);
    chk("f1_done_pulse", {31'd0, frame_done}, 32'd0);
    chk("f1_busy_after", {31'd0, busy}, 32'd0);
    // frame 2: dp on d5, hex letters, paused, right; d0 changes mid-frame
    {d5, d4, d3, d2, d1, d0} = {5'h1A, 5'h0, 5'h0, 5'h0F, 5'h0, 5'h0};
    en = 1'b0;
    dir = 1'b1;
    qm.delete();
    pulse_req();
    repeat (3) @(negedge clk);
    d0 = 5'h07;
    wait_done("f2_done");
    chk("f2_len", qm.size(), 12);
    for (int i = 0; i < 12 && i < qm.size(); i++) chk($sformatf("f2_byte%0d", i), {24'd0, qm[i]}, {24'd0, exp2[i]});
    // frame 3: back-pressure after the third byte
    {d5, d4, d3, d2, d1, d0} = {5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5};
    en = 1'b1;
    dir = 1'b0;
    repeat (3) @(negedge clk);
    qm.delete();
    pulse_req();
    wait_bytes(3, "f3_three_bytes");
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("f3_hold%0d", i), {31'd0, wr_uart}, 32'd0);
    end
    tx_full = 1'b0;
    @(negedge clk);
    chk("f3_resume_wr", {31'd0, wr_uart}, 32'd1);
    chk("f3_resume_data", {24'd0, w_data}, 32'h33);
    wait_done("f3_done");
    chk("f3_len", qm.size(), 11);
    for (int i = 0; i < 11 && i < qm.size(); i++) chk($sformatf("f3_byte%0d", i), {24'd0, qm[i]}, {24'd0, exp1[i]});
    // three reqs during a frame collapse into one extra frame
    repeat (3) @(negedge clk);
    qm.delete();
    tm.delete();
    pulse_req();
    repeat (2) @(negedge clk);
    pulse_req();
    pulse_req();
    pulse_req();
    wait_done("f4a_done");
    @(negedge clk);
    wait_done("f4b_done");
    repeat (40) @(negedge clk);
    chk("f4_len", qm.size(), 22);
    if (tm.size() == 22) chk("f4_gap", tm[11] - tm[10], 4);
    if (qm.size() == 22) chk("f4_second_first", {24'd0, qm[11]}, 32'h30);
    // req in the frame_done cycle is kept as pending
    qm.delete();
    pulse_req();
    wait_done("f5a_done");
    req = 1'b1;
    @(negedge clk) req = 1'b0;
    wait_done("f5b_done");
    repeat (40) @(negedge clk);
    chk("f5_len", qm.size(), 22);
    // reset in the middle of a frame
    qm.delete();
    pulse_req();
    wait_bytes(6, "f6_six_bytes");
    rst_n = 1'b0;
    #1;
    chk("f6_rst_wr", {31'd0, wr_uart}, 32'd0);
    chk("f6_rst_busy", {31'd0, busy}, 32'd0);
    chk("f6_rst_data", {24'd0, w_data}, 32'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("f6_truncated", qm.size(), 6);
    pulse_req();
    wait_done("f6_new_done");
    chk("f6_new_len", qm.size(), 17);
    // auto-report instance: one frame every 100 cycles, snapshot taken at frame start
    {d5, d4, d3, d2, d1, d0} = {5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5};
    qa.delete();
    fda.delete();
    @(negedge clk) rst_a = 1'b1;
    repeat (105) @(negedge clk);
    d0 = 5'h09;
    repeat (145) @(negedge clk);
    chk("auto_len", qa.size(), 22);
    chk("auto_frames", fda.size(), 2);
    if (fda.size() >= 2) chk("auto_period", fda[1] - fda[0], 100);
    if (qa.size() >= 17) begin
      chk("auto_old_d0", {24'd0, qa[5]}, 32'h35);
      chk("auto_new_d0", {24'd0, qa[16]}, 32'h39);
    end
    rst_a = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
